// File: rtl/prog_count_ctrl.sv
// prog_count_ctrl: run-control sequencer for a programmable 0..MAX_LIMIT
// up-counter. It latches and clamps the terminal value on start, steps the
// count once every TICK_DIV clocks, and supports pause and abort. The count
// is presented in binary and as a registered BCD pair (tens/ones).
module prog_count_ctrl #(
  parameter int WIDTH     = 7,
  parameter int MAX_LIMIT = 99,
  parameter int TICK_DIV  = 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] max_count,
  output logic [WIDTH-1:0] count_out,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             busy,
  output logic             done,
  output logic             clamped
);

  // The divider needs at least one bit even when every clock is a tick.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] LIMIT_W   = WIDTH'(MAX_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic             clamped_q, clamped_d;
  logic             busy_q, done_q;
  logic [3:0]       tens_q, ones_q;
  logic [3:0]       tens_d, ones_d;
  logic [WIDTH-1:0] start_lim;
  logic             step;

  // Next-state logic: abort overrides everything, then pause, then start.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lim_d     = lim_q;
    tick_d    = tick_q;
    clamped_d = clamped_q;
    step      = 1'b0;
    start_lim = (max_count > LIMIT_W) ? LIMIT_W : max_count;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lim_d     = start_lim;
          clamped_d = (max_count > LIMIT_W);
          count_d   = '0;
          tick_d    = '0;
          state_d   = (start_lim == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pause) state_d = PAUSE;
        else       step    = 1'b1;
      end
      PAUSE: begin
        // Releasing pause resumes counting on that same edge.
        if (!pause) begin
          state_d = RUN;
          step    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (step) begin
      if (tick_q == TICK_LAST) begin
        tick_d  = '0;
        count_d = count_q + WIDTH'(1);
        if (count_q + WIDTH'(1) == lim_q) state_d = DONE;
      end else begin
        tick_d = tick_q + DIV_W'(1);
      end
    end

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      tick_d  = '0;
    end
  end

  // Binary to BCD split of the current count; fed into a register stage.
  always_comb begin
    tens_d = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (count_q >= WIDTH'(i * 10)) tens_d = 4'(i);
    end
    ones_d = count_q[3:0] - 4'(tens_d * 4'd10);
  end

  // State, count and status registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      lim_q     <= '0;
      tick_q    <= '0;
      clamped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lim_q     <= lim_d;
      tick_q    <= tick_d;
      clamped_q <= clamped_d;
      busy_q    <= (state_d == RUN) || (state_d == PAUSE);
      done_q    <= (state_d == DONE);
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign count_out = count_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign clamped   = clamped_q;

endmodule

// File: tb/tb_prog_count_ctrl.sv
// Directed bench for prog_count_ctrl: one instance at TICK_DIV=1 and one at
// TICK_DIV=3 sharing the same stimulus.
module tb_prog_count_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n, start, pause, abort;
  logic [6:0] max_count;
  logic [6:0] count_out, c3_count;
  logic [3:0] bcd_tens, bcd_ones, c3_tens, c3_ones;
  logic       busy, done, clamped, c3_busy, c3_done, c3_clamped;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  prog_count_ctrl #(.WIDTH(7), .MAX_LIMIT(99), .TICK_DIV(1)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .max_count(max_count), .count_out(count_out), .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones), .busy(busy), .done(done), .clamped(clamped)
  );

  prog_count_ctrl #(.WIDTH(7), .MAX_LIMIT(99), .TICK_DIV(3)) dut3 (
    .CLK(CLK), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .max_count(max_count), .count_out(c3_count), .bcd_tens(c3_tens),
    .bcd_ones(c3_ones), .busy(c3_busy), .done(c3_done), .clamped(c3_clamped)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; pause = 1'b0; abort = 1'b0; max_count = 7'd5;

    // 1: reset held two edges, start ignored
    tick(); tick();
    check("rst_count", count_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clamped", clamped, 0);
    check("rst_tens", bcd_tens, 0);
    check("rst_ones", bcd_ones, 0);
    check("rst_c3_count", c3_count, 0);

    // 2: max 5, count 0..5 on consecutive edges
    rst_n = 1'b1;
    tick();
    check("t2_count0", count_out, 0);
    check("t2_busy0", busy, 1);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t2_count%0d", k), count_out, k);
      check($sformatf("t2_ones_lag%0d", k), bcd_ones, k - 1);
    end
    check("t2_done", done, 1);
    check("t2_busy_end", busy, 0);
    tick();
    check("t2_hold", count_out, 5);
    check("t2_tens", bcd_tens, 0);
    check("t2_ones", bcd_ones, 5);

    // 3: max 120 clamps to 99
    max_count = 7'd120; start = 1'b1;
    tick();
    check("t3_count0", count_out, 0);
    check("t3_clamped", clamped, 1);
    start = 1'b0;
    for (int k = 1; k <= 98; k++) tick();
    check("t3_count98", count_out, 98);
    check("t3_notdone98", done, 0);
    tick();
    check("t3_count99", count_out, 99);
    check("t3_done", done, 1);
    tick();
    check("t3_hold99", count_out, 99);
    check("t3_tens", bcd_tens, 9);
    check("t3_ones", bcd_ones, 9);

    // 4: max 20, pause at count 3 for 4 edges
    max_count = 7'd20; start = 1'b1;
    tick();
    check("t4_clamped", clamped, 0);
    start = 1'b0;
    tick(); tick(); tick();
    check("t4_count3", count_out, 3);
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t4_pause_count_%0d", k), count_out, 3);
      check($sformatf("t4_pause_busy_%0d", k), busy, 1);
    end
    pause = 1'b0;
    tick();
    check("t4_resume", count_out, 4);

    // 5: start held during RUN does not restart; abort at 7
    start = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      tick();
      check($sformatf("t5_norestart%0d", k), count_out, k);
    end
    abort = 1'b1;
    tick();
    check("t5_abort_count", count_out, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 0);
    abort = 1'b0; start = 1'b0;
    tick();
    check("t5_idle_count", count_out, 0);
    check("t5_idle_busy", busy, 0);
    max_count = 7'd0; start = 1'b1;
    tick();
    check("t5_zero_done", done, 1);
    check("t5_zero_count", count_out, 0);
    check("t5_zero_busy", busy, 0);

    // 6: reset mid-run, then reach 37
    max_count = 7'd40;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    check("t6_count12", count_out, 12);
    rst_n = 1'b0;
    tick();
    check("t6_rst_count", count_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 37; k++) tick();
    check("t6_count37", count_out, 37);
    tick();
    check("t6_tens", bcd_tens, 3);
    check("t6_ones", bcd_ones, 7);

    // TICK_DIV=3 instance: three clocks per step
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; max_count = 7'd2; start = 1'b1;
    tick();
    check("d3_count0", c3_count, 0);
    check("d3_busy0", c3_busy, 1);
    start = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("d3_count_e%0d", e), c3_count, e / 3);
      check($sformatf("d3_done_e%0d", e), c3_done, (e == 6) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
